// File: rtl/frame_mem_arbiter_if.sv
// rtl/frame_mem_arbiter_if.sv - display/host/RAM bus bundle for frame_mem_arbiter
// Purpose: groups the display pixel-fetch port, the host load/readback port and
// the frame RAM port. The arbiter connects through the slave modport; the
// requesters and the RAM (or a bench standing in for them) use master.
//   disp_*  : display coordinate request and pixel response
//   host_*  : host single-beat read/write with ack and read-data pulse
//   ram_*   : registered single-port RAM address/write, 1-cycle read data
interface frame_mem_arbiter_if #(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT)
);
  localparam int XW = $clog2(IMG_WIDTH);
  localparam int YW = $clog2(IMG_HEIGHT);

  logic                  disp_req;
  logic [XW-1:0]         disp_x;
  logic [YW-1:0]         disp_y;
  logic [DATA_WIDTH-1:0] disp_data;
  logic                  disp_valid;
  logic                  disp_stale;

  logic                  host_req;
  logic                  host_we;
  logic [ADDR_WIDTH-1:0] host_addr;
  logic [DATA_WIDTH-1:0] host_wdata;
  logic                  host_ack;
  logic [DATA_WIDTH-1:0] host_rdata;
  logic                  host_rvalid;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_wdata;
  logic [DATA_WIDTH-1:0] ram_rdata;

  modport slave (
    input  disp_req, disp_x, disp_y,
    output disp_data, disp_valid, disp_stale,
    input  host_req, host_we, host_addr, host_wdata,
    output host_ack, host_rdata, host_rvalid,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output disp_req, disp_x, disp_y,
    input  disp_data, disp_valid, disp_stale,
    output host_req, host_we, host_addr, host_wdata,
    input  host_ack, host_rdata, host_rvalid,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );
endinterface

// File: rtl/frame_mem_arbiter.sv
// rtl/frame_mem_arbiter.sv - frame RAM arbiter between display fetch and host port
// Purpose: one RAM slot per cycle. Display wins unless the host has waited
// MAX_WAIT-1 denied cycles, in which case the host is forced through and the
// display slot answers with a stale (repeated) pixel. Every display request
// gets a response exactly two edges after its sampling edge; host reads return
// on the same schedule.
// Ports:
//   clk    : system clock
//   reset  : asynchronous, active-high; clears outputs, wait counter and the
//            response pipeline
//   bus    : frame_mem_arbiter_if.slave (display, host and RAM signals)
module frame_mem_arbiter #(
  parameter int IMG_WIDTH  = 160,
  parameter int IMG_HEIGHT = 120,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = $clog2(IMG_WIDTH * IMG_HEIGHT),
  parameter int MAX_WAIT   = 8
) (
  input logic                 clk,
  input logic                 reset,
  frame_mem_arbiter_if.slave  bus
);
  localparam int WW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_LIMIT = WW'(MAX_WAIT - 1);

  // What a display slot will return once it reaches the output stage.
  typedef enum logic [1:0] {
    SLOT_NONE,
    SLOT_RAM,
    SLOT_ZERO,
    SLOT_STALE
  } slot_e;

  logic [ADDR_WIDTH-1:0] disp_addr;
  logic                  disp_in_range;
  logic                  host_ok;
  logic                  forced;
  logic                  disp_grant;
  logic                  host_grant;

  logic [WW-1:0]         wait_cnt_q,    wait_cnt_d;
  logic                  host_ack_q,    host_ack_d;
  logic [ADDR_WIDTH-1:0] ram_addr_q,    ram_addr_d;
  logic                  ram_we_q,      ram_we_d;
  logic [DATA_WIDTH-1:0] ram_wdata_q,   ram_wdata_d;
  slot_e                 slot1_q,       slot1_d;
  slot_e                 slot2_q,       slot2_d;
  logic                  hrd1_q,        hrd1_d;
  logic                  hrd2_q,        hrd2_d;
  logic [DATA_WIDTH-1:0] disp_data_q,   disp_data_d;
  logic                  disp_valid_q,  disp_valid_d;
  logic                  disp_stale_q,  disp_stale_d;
  logic [DATA_WIDTH-1:0] host_rdata_q,  host_rdata_d;
  logic                  host_rvalid_q, host_rvalid_d;

  always_comb begin
    disp_addr     = ADDR_WIDTH'(bus.disp_y) * ADDR_WIDTH'(IMG_WIDTH)
                  + ADDR_WIDTH'(bus.disp_x);
    disp_in_range = (int'(bus.disp_x) < IMG_WIDTH) && (int'(bus.disp_y) < IMG_HEIGHT);

    // A request presented in the ack cycle is a new transaction and only
    // competes from the next cycle on.
    host_ok    = bus.host_req && !host_ack_q;
    forced     = host_ok && (wait_cnt_q == WAIT_LIMIT);
    disp_grant = bus.disp_req && disp_in_range && !forced;
    host_grant = host_ok && !disp_grant;

    wait_cnt_d = wait_cnt_q;
    if (!bus.host_req || host_grant) begin
      wait_cnt_d = '0;
    end else if (!host_ack_q && (wait_cnt_q != WAIT_LIMIT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end

    ram_addr_d  = ram_addr_q;
    ram_we_d    = 1'b0;
    ram_wdata_d = ram_wdata_q;
    if (disp_grant) begin
      ram_addr_d = disp_addr;
    end else if (host_grant) begin
      ram_addr_d = bus.host_addr;
      ram_we_d   = bus.host_we;
      if (bus.host_we) begin
        ram_wdata_d = bus.host_wdata;
      end
    end
    host_ack_d = host_grant;

    if (!bus.disp_req) begin
      slot1_d = SLOT_NONE;
    end else if (!disp_in_range) begin
      slot1_d = SLOT_ZERO;
    end else if (disp_grant) begin
      slot1_d = SLOT_RAM;
    end else begin
      slot1_d = SLOT_STALE;
    end
    hrd1_d = host_grant && !bus.host_we;

    // Stage 2 just waits out the RAM read latency.
    slot2_d = slot1_q;
    hrd2_d  = hrd1_q;

    disp_valid_d = (slot2_q != SLOT_NONE);
    disp_stale_d = (slot2_q == SLOT_STALE);
    case (slot2_q)
      SLOT_RAM:  disp_data_d = bus.ram_rdata;
      SLOT_ZERO: disp_data_d = '0;
      default:   disp_data_d = disp_data_q;
    endcase

    host_rvalid_d = hrd2_q;
    host_rdata_d  = hrd2_q ? bus.ram_rdata : host_rdata_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt_q    <= '0;
      host_ack_q    <= 1'b0;
      ram_addr_q    <= '0;
      ram_we_q      <= 1'b0;
      ram_wdata_q   <= '0;
      slot1_q       <= SLOT_NONE;
      slot2_q       <= SLOT_NONE;
      hrd1_q        <= 1'b0;
      hrd2_q        <= 1'b0;
      disp_data_q   <= '0;
      disp_valid_q  <= 1'b0;
      disp_stale_q  <= 1'b0;
      host_rdata_q  <= '0;
      host_rvalid_q <= 1'b0;
    end else begin
      wait_cnt_q    <= wait_cnt_d;
      host_ack_q    <= host_ack_d;
      ram_addr_q    <= ram_addr_d;
      ram_we_q      <= ram_we_d;
      ram_wdata_q   <= ram_wdata_d;
      slot1_q       <= slot1_d;
      slot2_q       <= slot2_d;
      hrd1_q        <= hrd1_d;
      hrd2_q        <= hrd2_d;
      disp_data_q   <= disp_data_d;
      disp_valid_q  <= disp_valid_d;
      disp_stale_q  <= disp_stale_d;
      host_rdata_q  <= host_rdata_d;
      host_rvalid_q <= host_rvalid_d;
    end
  end

  assign bus.disp_data   = disp_data_q;
  assign bus.disp_valid  = disp_valid_q;
  assign bus.disp_stale  = disp_stale_q;
  assign bus.host_ack    = host_ack_q;
  assign bus.host_rdata  = host_rdata_q;
  assign bus.host_rvalid = host_rvalid_q;
  assign bus.ram_addr    = ram_addr_q;
  assign bus.ram_we      = ram_we_q;
  assign bus.ram_wdata   = ram_wdata_q;
endmodule

// File: tb/tb_frame_mem_arbiter.sv
// tb/tb_frame_mem_arbiter.sv - scoreboard bench for frame_mem_arbiter
// Purpose: drives display/host vectors, models the frame RAM with 1-cycle read
// latency, and checks every response against hand-computed expectations.
module tb_frame_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  logic ram_clr;
  always #5 clk = ~clk;

  frame_mem_arbiter_if #(.IMG_WIDTH(160), .IMG_HEIGHT(120), .DATA_WIDTH(8), .ADDR_WIDTH(15)) bus();

  frame_mem_arbiter #(
    .IMG_WIDTH(160), .IMG_HEIGHT(120), .DATA_WIDTH(8), .ADDR_WIDTH(15), .MAX_WAIT(8)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM model: untouched locations hold (x+y) mod 256.
  logic [7:0]     wmem [0:32767];
  logic [32767:0] wvalid;

  function automatic logic [7:0] pix(input int a);
    return 8'((a % 160) + (a / 160));
  endfunction

  always @(posedge clk) begin
    if (ram_clr) begin
      wvalid <= '0;
    end else if (bus.ram_we) begin
      wmem[bus.ram_addr]   <= bus.ram_wdata;
      wvalid[bus.ram_addr] <= 1'b1;
    end
    bus.ram_rdata <= wvalid[bus.ram_addr] ? wmem[bus.ram_addr] : pix(int'(bus.ram_addr));
  end

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  typedef struct {
    int e;
    int a;
    int d;
    int s;
  } exp_t;

  exp_t q_disp[$];
  exp_t q_ack[$];
  exp_t q_wr[$];
  exp_t q_rd[$];
  exp_t mx;

  function automatic exp_t mk(input int e, input int a, input int d, input int s);
    exp_t x;
    x.e = e; x.a = a; x.d = d; x.s = s;
    return x;
  endfunction

  // Monitor: every pulse observed must match the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.disp_valid) begin
        if (q_disp.size() == 0) check("disp_unexpected", bus.disp_valid, 0);
        else begin
          mx = q_disp.pop_front();
          check("disp_edge", edge_n, mx.e);
          check("disp_data", bus.disp_data, mx.d);
          check("disp_stale", bus.disp_stale, mx.s);
        end
      end
      if (bus.host_ack) begin
        if (q_ack.size() == 0) check("ack_unexpected", bus.host_ack, 0);
        else begin
          mx = q_ack.pop_front();
          check("ack_edge", edge_n, mx.e);
        end
      end
      if (bus.ram_we) begin
        if (q_wr.size() == 0) check("ram_we_unexpected", bus.ram_we, 0);
        else begin
          mx = q_wr.pop_front();
          check("wr_edge", edge_n, mx.e);
          check("wr_addr", bus.ram_addr, mx.a);
          check("wr_data", bus.ram_wdata, mx.d);
        end
      end
      if (bus.host_rvalid) begin
        if (q_rd.size() == 0) check("rvalid_unexpected", bus.host_rvalid, 0);
        else begin
          mx = q_rd.pop_front();
          check("rd_edge", edge_n, mx.e);
          check("rd_data", bus.host_rdata, mx.d);
        end
      end
    end
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic r, input int x, input int y);
    bus.disp_req = r;
    bus.disp_x   = 8'(x);
    bus.disp_y   = 7'(y);
  endtask

  task automatic set_host(input logic r, input logic we, input int a, input int d);
    bus.host_req   = r;
    bus.host_we    = we;
    bus.host_addr  = 15'(a);
    bus.host_wdata = 8'(d);
  endtask

  task automatic check_zero(input string name);
    check(name, {bus.disp_data, bus.disp_valid, bus.disp_stale, bus.host_ack,
                 bus.host_rdata, bus.host_rvalid, bus.ram_addr, bus.ram_we,
                 bus.ram_wdata}, 64'd0);
  endtask

  int gg;
  int t;
  logic stale;

  initial begin
    reset   = 1'b1;
    ram_clr = 1'b1;
    set_disp(0, 0, 0);
    set_host(0, 0, 0, 0);
    nxt();
    nxt();
    check_zero("reset_state");
    ram_clr = 1'b0;
    reset   = 1'b0;
    nxt();
    nxt();

    // Display stream: three consecutive pixels, answers two edges later.
    gg = edge_n + 1;
    set_disp(1, 0, 0);   q_disp.push_back(mk(gg + 2, 0, 0, 0));   nxt();
    set_disp(1, 159, 0); q_disp.push_back(mk(gg + 3, 0, 159, 0)); nxt();
    set_disp(1, 5, 119); q_disp.push_back(mk(gg + 4, 0, 124, 0)); nxt();
    set_disp(0, 0, 0);
    repeat (4) nxt();

    // Host write 0xA5 @1234, then read it back (presented in the ack cycle).
    gg = edge_n + 1;
    set_host(1, 1, 1234, 8'hA5);
    q_ack.push_back(mk(gg, 0, 0, 0));
    q_wr.push_back(mk(gg, 1234, 8'hA5, 0));
    nxt();
    set_host(1, 0, 1234, 0);
    q_ack.push_back(mk(gg + 2, 0, 0, 0));
    q_rd.push_back(mk(gg + 4, 0, 8'hA5, 0));
    nxt();
    nxt();
    set_host(0, 0, 0, 0);
    repeat (5) nxt();

    // Starvation: display every cycle at (k,1); host forced at k=7 and,
    // after the counter clears, again at k=16.
    gg = edge_n + 1;
    for (int k = 0; k < 20; k++) begin
      set_disp(1, k, 1);
      stale = (k == 7) || (k == 16);
      q_disp.push_back(mk(gg + k + 2, 0, stale ? k : k + 1, int'(stale)));
      if (k == 0) begin
        set_host(1, 1, 500, 8'h3C);
        q_ack.push_back(mk(gg + 7, 0, 0, 0));
        q_wr.push_back(mk(gg + 7, 500, 8'h3C, 0));
      end
      if (k == 8) begin
        check("starve_ack_seen", bus.host_ack, 1);
        set_host(1, 1, 501, 8'h5A);
        q_ack.push_back(mk(gg + 16, 0, 0, 0));
        q_wr.push_back(mk(gg + 16, 501, 8'h5A, 0));
      end
      if (k == 17) set_host(0, 0, 0, 0);
      nxt();
    end
    set_disp(0, 0, 0);
    repeat (4) nxt();

    // Out-of-range coordinates: host takes the slot, display gets zeros.
    gg = edge_n + 1;
    set_disp(1, 160, 0);
    set_host(1, 1, 2000, 8'h77);
    q_ack.push_back(mk(gg, 0, 0, 0));
    q_wr.push_back(mk(gg, 2000, 8'h77, 0));
    q_disp.push_back(mk(gg + 2, 0, 0, 0));
    nxt();
    set_disp(1, 0, 120);
    set_host(0, 0, 0, 0);
    q_disp.push_back(mk(gg + 3, 0, 0, 0));
    nxt();
    set_disp(0, 0, 0);
    check("oor_ram_addr_held", bus.ram_addr, 2000);
    check("oor_ram_we", bus.ram_we, 0);
    repeat (4) nxt();

    // Back-to-back host writes: next one presented in each ack cycle.
    gg = edge_n + 1;
    for (int i = 0; i < 4; i++) begin
      q_ack.push_back(mk(gg + 2 * i, 0, 0, 0));
      q_wr.push_back(mk(gg + 2 * i, 3000 + i, 8'h10 + i, 0));
    end
    for (int i = 0; i < 4; i++) begin
      set_host(1, 1, 3000 + i, 8'h10 + i);
      t = 0;
      do begin
        nxt();
        t++;
      end while (!bus.host_ack && t < 10);
      if (t >= 10) check("b2b_ack_timeout", bus.host_ack, 1);
    end
    set_host(0, 0, 0, 0);
    repeat (4) nxt();

    // Reset one cycle after a host read grant, with a display fetch in flight.
    gg = edge_n + 1;
    set_disp(1, 3, 3);
    nxt();
    set_disp(0, 0, 0);
    set_host(1, 0, 1234, 0);
    q_ack.push_back(mk(gg + 1, 0, 0, 0));
    nxt();
    set_host(0, 0, 0, 0);
    nxt();
    reset = 1'b1;
    #1;
    check_zero("reset_async_outputs");
    nxt();
    nxt();
    reset = 1'b0;
    repeat (8) nxt();

    check("q_disp_drained", q_disp.size(), 0);
    check("q_ack_drained", q_ack.size(), 0);
    check("q_wr_drained", q_wr.size(), 0);
    check("q_rd_drained", q_rd.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/frame_mem_arbiter.md
# frame_mem_arbiter

Shares the single-port image frame RAM between the display read path (zoom datapath pixel fetches driven by VGA coordinates) and a host port that loads or reads back the image. The display path has priority every cycle. A bounded-wait counter guarantees host progress, and the RAM's 1-cycle read latency is absorbed into a fixed 2-cycle response pipeline. The block sits between the zoom in/out datapaths and the frame RAM, converting (x, y) pixel coordinates into linear RAM addresses.

## Interface
- IMG_WIDTH, 160, image width in pixels
- IMG_HEIGHT, 120, image height in pixels
- DATA_WIDTH, 8, pixel width
- ADDR_WIDTH, $clog2(IMG_WIDTH*IMG_HEIGHT), linear RAM address width
- MAX_WAIT, 8, max consecutive denied cycles for a pending host request (>=2)
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high
- disp_req  in  1  display wants pixel (disp_x, disp_y) this cycle
- disp_x  in  $clog2(IMG_WIDTH)  pixel column
- disp_y  in  $clog2(IMG_HEIGHT)  pixel row
- disp_data  out  DATA_WIDTH  returned pixel
- disp_valid  out  1  disp_data valid
- disp_stale  out  1  with disp_valid: request was preempted; disp_data repeats the last delivered pixel
- host_req  in  1  host transaction pending; hold stable until host_ack
- host_we  in  1  1 = write, 0 = read
- host_addr  in  ADDR_WIDTH  linear address
- host_wdata  in  DATA_WIDTH  write data
- host_ack  out  1  1-cycle pulse: transaction accepted
- host_rdata  out  DATA_WIDTH  read data
- host_rvalid  out  1  host_rdata valid (reads only)
- ram_addr  out  ADDR_WIDTH  RAM address (registered)
- ram_we  out  1  RAM write enable (registered)
- ram_wdata  out  DATA_WIDTH  RAM write data (registered)
- ram_rdata  in  DATA_WIDTH  RAM read data; valid 1 cycle after ram_addr

## Operation
- Display linear address is disp_y*IMG_WIDTH + disp_x, computed at full ADDR_WIDTH with no truncation.
- If disp_x >= IMG_WIDTH or disp_y >= IMG_HEIGHT:
  - No RAM access is made and the host may take the slot.
  - The response still returns disp_valid=1, disp_data=0, disp_stale=0.
- Grant decision is made each cycle on sampled inputs. Priority:
  1. Host, if host_req=1, host_ack is not currently high, and wait_cnt==MAX_WAIT-1 (forced).
  2. Display, if disp_req=1 and in range.
  3. Host, if host_req=1 and host_ack is not currently high.
  4. Idle: ram_we=0, ram_addr holds its value.
- wait_cnt:
  - Increments each cycle host_req=1 and the host is denied, excluding the cycle in which host_ack is high.
  - Clears on host grant or when host_req=0.
  - Saturates at MAX_WAIT-1.
- Preempted display request (forced host grant while disp_req=1): the response slot still produces disp_valid=1, disp_stale=1, disp_data = last disp_data value.
- Host write:
  - ram_we=1 for exactly one cycle.
  - host_ack pulses.
  - No host_rvalid.
- Host read: host_ack pulses, then host_rvalid pulses with RAM data.
- Host-side rules:
  - A new transaction may be presented in the host_ack cycle.
  - It is not considered for grant until the following cycle, so there is at least one cycle between consecutive host grants.
- Only one requester is granted per cycle. Same-address host write and display read in the same cycle cannot occur.

## Timing
- Edge E0 samples the request and decides the grant.
- After E0:
  - ram_addr, ram_we, ram_wdata are driven.
  - host_ack=1 if the host was granted.
- After E1: ram_rdata is valid.
- After E2:
  - disp_valid/disp_data is asserted for a display slot, including out-of-range and preempted slots.
  - host_rvalid/host_rdata is asserted for a host read.
- Display latency is fixed at 2 cycles from the disp_req cycle, and throughput is 1 per cycle. A gap in disp_req produces a gap in disp_valid.
- All valid/ack pulses last 1 cycle. disp_data and host_rdata hold their values between pulses.
- Reset (asynchronous, at any time):
  - All outputs go to 0.
  - wait_cnt=0.
  - Response pipeline is flushed, so in-flight responses are discarded.
  - A host transaction acked but unanswered must be reissued after reset.
- Worst-case host wait under continuous display traffic: MAX_WAIT cycles from host_req to grant.

## Test plan
- **Display stream.** Preload RAM[y*160+x] = (x+y) mod 256. Request (0,0), (159,0), (5,119) on consecutive cycles. Required response, 2 cycles later on consecutive cycles: disp_data 0, 159, 124 with disp_valid=1 and disp_stale=0.
- **Host write then read, display idle.** Write 0xA5 to address 1234, then read 1234. Required: host_ack one cycle after each grant; ram_we high exactly 1 cycle; host_rvalid 2 cycles after the read grant with host_rdata=0xA5.
- **Starvation, MAX_WAIT=8, display requesting every cycle.**
  - host_req rises at cycle 0; host granted at cycle 7.
  - That display slot returns disp_stale=1 with disp_data repeating the previous pixel.
  - wait_cnt clears after the grant.
- **Out-of-range request.** Request (160,0), then (0,120), with host_req pending. Required: host granted in the first slot; disp_valid=1 with disp_data=0 for both; no display RAM access.
- **Back-to-back host writes.** Hold host_req=1 with new data in each ack cycle. Required: grants are spaced at least 2 cycles apart; each write is acked exactly once.
- **Reset mid-read.** Assert reset one cycle after a host read grant. Required: all outputs 0 immediately, and no host_rvalid or disp_valid after reset is released.
